// File: rtl/pipelined_alu_datapath_if.sv
// Handshake and bus bundle for pipelined_alu_datapath. The slave modport is the
// datapath's view. The master modport is the view of the fetch/decode driver and
// the commit consumer.
interface pipelined_alu_datapath_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      ir;
  logic             ext_sel;
  logic [WIDTH-1:0] ext_data;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rc;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_err;
  logic [4:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output in_valid, ir, ext_sel, ext_data, out_ready, dbg_addr,
    input  in_ready, out_valid, out_rc, out_data, out_ovf, out_err, dbg_data
  );

  modport slave (
    input  in_valid, ir, ext_sel, ext_data, out_ready, dbg_addr,
    output in_ready, out_valid, out_rc, out_data, out_ovf, out_err, dbg_data
  );
endinterface

// File: rtl/pipelined_alu_datapath.sv
// Two-stage accept/commit ALU datapath with a register file.
// Stage 1 latches decoded fields and operands, with forwarding from the
// committing instruction. Stage 2 evaluates the ALU combinationally from the
// latched operands and writes Rc when the downstream consumer takes the result.
module pipelined_alu_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_alu_datapath_if.slave bus
);

  typedef struct packed {
    logic [4:0]       rc;
    logic [3:0]       fn;
    logic             ext_sel;
    logic [WIDTH-1:0] ext_data;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t                        st_q, st_d;
  logic                          vld_q, vld_d;
  logic [NREGS-1:0][WIDTH-1:0]   rf_q, rf_d;

  logic                          accept, commit, wr_en;
  logic [WIDTH-1:0]              res, lit_ext, op_a, op_b;
  logic                          ovf, err;
  logic [SHW-1:0]                sh;
  logic signed [15:0]            lit_s;
  logic                          unused_ir31;

  // Indices at or above NREGS have no storage behind them, so they read as 0.
  function automatic logic [WIDTH-1:0] rf_read(input logic [NREGS-1:0][WIDTH-1:0] rf,
                                               input logic [4:0] idx);
    rf_read = '0;
    for (int i = 0; i < NREGS; i++)
      if (idx == 5'(i)) rf_read = rf[i];
  endfunction

  assign unused_ir31   = bus.ir[31];
  assign lit_s         = bus.ir[15:0];
  assign lit_ext       = WIDTH'(lit_s);
  assign bus.in_ready  = !vld_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign commit        = vld_q && bus.out_ready;
  assign wr_en         = commit && !err && (int'(st_q.rc) < NREGS);
  assign bus.out_valid = vld_q;
  assign bus.out_rc    = st_q.rc;
  assign bus.out_data  = res;
  assign bus.out_ovf   = ovf;
  assign bus.out_err   = err;
  assign bus.dbg_data  = rf_read(rf_q, bus.dbg_addr);

  // Commit-stage ALU. Every result is derived from the latched operands only.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    err = 1'b0;
    sh  = st_q.b[SHW-1:0];
    if (st_q.ext_sel) begin
      res = st_q.ext_data;
    end else begin
      case (st_q.fn)
        4'b0000: begin
          res = st_q.a + st_q.b;
          ovf = (st_q.a[WIDTH-1] == st_q.b[WIDTH-1]) && (res[WIDTH-1] != st_q.a[WIDTH-1]);
        end
        4'b0001: begin
          res = st_q.a - st_q.b;
          ovf = (st_q.a[WIDTH-1] != st_q.b[WIDTH-1]) && (res[WIDTH-1] != st_q.a[WIDTH-1]);
        end
        4'b0100: res[0] = (st_q.a == st_q.b);
        4'b0101: res[0] = ($signed(st_q.a) <  $signed(st_q.b));
        4'b0110: res[0] = ($signed(st_q.a) <= $signed(st_q.b));
        4'b1000: res = st_q.a & st_q.b;
        4'b1001: res = st_q.a | st_q.b;
        4'b1010: res = st_q.a ^ st_q.b;
        4'b1011: res = ~(st_q.a ^ st_q.b);
        4'b1100: res = st_q.a << sh;
        4'b1101: res = st_q.a >> sh;
        4'b1110: res = $signed(st_q.a) >>> sh;
        default: err = 1'b1;
      endcase
    end
  end

  // Operand select. A commit that writes the register being read this same
  // cycle wins over the not-yet-updated file contents.
  always_comb begin
    op_a = (wr_en && st_q.rc == bus.ir[20:16]) ? res : rf_read(rf_q, bus.ir[20:16]);
    if (bus.ir[30])
      op_b = lit_ext;
    else
      op_b = (wr_en && st_q.rc == bus.ir[15:11]) ? res : rf_read(rf_q, bus.ir[15:11]);
  end

  // Next-state logic for the stage register, the valid bit and the register file.
  always_comb begin
    st_d  = st_q;
    vld_d = vld_q;
    rf_d  = rf_q;
    if (accept) begin
      st_d.rc       = bus.ir[25:21];
      st_d.fn       = bus.ir[29:26];
      st_d.ext_sel  = bus.ext_sel;
      st_d.ext_data = bus.ext_data;
      st_d.a        = op_a;
      st_d.b        = op_b;
      vld_d         = 1'b1;
    end else if (commit) begin
      vld_d = 1'b0;
    end
    for (int i = 0; i < NREGS; i++)
      if (wr_en && st_q.rc == 5'(i)) rf_d[i] = res;
  end

  // State registers. Reset discards any in-flight instruction and clears the file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= '0;
      vld_q <= 1'b0;
      rf_q  <= '0;
    end else begin
      st_q  <= st_d;
      vld_q <= vld_d;
      rf_q  <= rf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_alu_datapath.sv
// Bench for pipelined_alu_datapath. Expected results come from a sequential
// instruction-level model. Results are queued in issue order and compared at
// commit. Debug reads are checked against the architectural state committed so far.
module tb_pipelined_alu_datapath;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_alu_datapath_if #(.WIDTH(32)) bus ();
  pipelined_alu_datapath_if #(.WIDTH(16)) bus2 ();

  pipelined_alu_datapath #(.WIDTH(32), .NREGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_alu_datapath #(.WIDTH(16), .NREGS(8))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    logic [4:0]  rc;
    logic [31:0] data;
    logic        ovf;
    logic        err;
    logic        we;
  } exp_t;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] arf [32];   // issue-order architectural state
  logic [31:0] crf [32];   // state after observed commits
  exp_t        q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic ls, input logic [3:0] fn, input logic [4:0] rc,
                                     input logic [4:0] ra, input logic [15:0] low);
    return {1'b0, ls, fn, rc, ra, low};
  endfunction

  function automatic logic [15:0] rr(input logic [4:0] rb);
    return {rb, 11'h0};
  endfunction

  // One instruction executed in program order, in plain signed arithmetic.
  function automatic exp_t model(input logic [31:0] ir, input logic es, input logic [31:0] ed);
    exp_t        e;
    logic [31:0] a, b;
    longint      sa, sb, r;
    int          sh;
    e.rc  = ir[25:21];
    e.ovf = 1'b0;
    e.err = 1'b0;
    a  = arf[ir[20:16]];
    b  = ir[30] ? {{16{ir[15]}}, ir[15:0]} : arf[ir[15:11]];
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    case (ir[29:26])
      4'd0:  begin r = sa + sb; e.ovf = (r > MAXS) || (r < MINS); end
      4'd1:  begin r = sa - sb; e.ovf = (r > MAXS) || (r < MINS); end
      4'd4:  r = (a == b) ? 1 : 0;
      4'd5:  r = (sa < sb) ? 1 : 0;
      4'd6:  r = (sa <= sb) ? 1 : 0;
      4'd8:  r = longint'(a & b);
      4'd9:  r = longint'(a | b);
      4'd10: r = longint'(a ^ b);
      4'd11: r = longint'(~(a ^ b));
      4'd12: r = longint'(a) << sh;
      4'd13: r = longint'(a >> sh);
      4'd14: r = sa >>> sh;
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.data = r[31:0];
    if (es) begin
      e.data = ed;
      e.ovf  = 1'b0;
      e.err  = 1'b0;
    end
    e.we = !e.err;
    return e;
  endfunction

  // Drive one cycle, check outputs before the edge, and advance both models.
  task automatic step(input logic v, input logic [31:0] ir, input logic es,
                      input logic [31:0] ed, input logic ordy, input logic [4:0] dbg);
    logic acc;
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.ir        = ir;
    bus.ext_sel   = es;
    bus.ext_data  = ed;
    bus.out_ready = ordy;
    bus.dbg_addr  = dbg;
    #1;
    acc = v && (q.size() == 0 || ordy);
    chk("out_valid", {63'b0, bus.out_valid}, {63'b0, q.size() != 0});
    chk("in_ready",  {63'b0, bus.in_ready},  {63'b0, (q.size() == 0) || ordy});
    chk("dbg_data",  {32'b0, bus.dbg_data},  {32'b0, crf[dbg]});
    if (q.size() != 0) begin
      chk("out_rc",   {59'b0, bus.out_rc},   {59'b0, q[0].rc});
      chk("out_data", {32'b0, bus.out_data}, {32'b0, q[0].data});
      chk("out_ovf",  {63'b0, bus.out_ovf},  {63'b0, q[0].ovf});
      chk("out_err",  {63'b0, bus.out_err},  {63'b0, q[0].err});
      if (ordy) begin
        if (q[0].we) crf[q[0].rc] = q[0].data;
        void'(q.pop_front());
      end
    end
    if (acc) begin
      e = model(ir, es, ed);
      q.push_back(e);
      if (e.we) arf[e.rc] = e.data;
    end
  endtask

  task automatic idle_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dbg_addr = addr;
    #1;
    chk(tag, {32'b0, bus.dbg_data}, {32'b0, exp});
  endtask

  task automatic drain();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.ir = '0; bus.ext_sel = 1'b0; bus.ext_data = '0;
    bus.out_ready = 1'b1; bus.dbg_addr = '0;
    bus2.in_valid = 1'b0; bus2.ir = '0; bus2.ext_sel = 1'b0; bus2.ext_data = '0;
    bus2.out_ready = 1'b1; bus2.dbg_addr = '0;
    for (int i = 0; i < 32; i++) begin arf[i] = '0; crf[i] = '0; end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_out_data",  {32'b0, bus.out_data},  64'd0);
    chk("rst_out_rc",    {59'b0, bus.out_rc},    64'd0);
    chk("rst_out_ovf",   {63'b0, bus.out_ovf},   64'd0);
    chk("rst_out_err",   {63'b0, bus.out_err},   64'd0);
    chk("rst_dbg",       {32'b0, bus.dbg_data},  64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  {63'b0, bus.in_ready},  64'd1);

    // Load path
    step(1, mk(0, 4'd0, 5'd4,  5'd0, 16'h0), 1, 32'd4,        1, 5'd4);
    step(1, mk(0, 4'd0, 5'd7,  5'd0, 16'h0), 1, 32'd7,        1, 5'd4);
    step(1, mk(0, 4'd0, 5'd16, 5'd0, 16'h0), 1, 32'h80000000, 1, 5'd4);
    // Back-to-back dependency: SUB reads R11 from the committing ADD
    step(1, mk(0, 4'b0000, 5'd11, 5'd4,  rr(5'd7)), 0, 0, 1, 5'd7);
    step(1, mk(0, 4'b0001, 5'd12, 5'd11, rr(5'd4)), 0, 0, 1, 5'd16);
    // Literals, sign extension and shifts
    step(1, mk(1, 4'b0000, 5'd30, 5'd4,  16'hFF00), 0, 0, 1, 5'd11);
    step(1, mk(1, 4'b1110, 5'd20, 5'd16, 16'h0001), 0, 0, 1, 5'd12);
    step(1, mk(1, 4'b1101, 5'd21, 5'd16, 16'h0001), 0, 0, 1, 5'd30);
    // Overflow, compare, XNOR and an illegal opcode
    step(1, mk(0, 4'd0,    5'd1,  5'd0,  16'h0), 1, 32'h7FFFFFFF, 1, 5'd20);
    step(1, mk(1, 4'b0000, 5'd2,  5'd1,  16'h0001), 0, 0, 1, 5'd21);
    step(1, mk(1, 4'b0101, 5'd3,  5'd16, 16'h0001), 0, 0, 1, 5'd1);
    step(1, mk(0, 4'd0,    5'd9,  5'd0,  16'h0), 1, 32'd9, 1, 5'd2);
    step(1, mk(0, 4'b1011, 5'd5,  5'd9,  rr(5'd7)), 0, 0, 1, 5'd3);
    step(1, mk(0, 4'b0111, 5'd4,  5'd9,  rr(5'd7)), 0, 0, 1, 5'd4);
    drain();
    idle_chk("R4",  5'd4,  32'd4);
    idle_chk("R7",  5'd7,  32'd7);
    idle_chk("R16", 5'd16, 32'h80000000);
    idle_chk("R11", 5'd11, 32'd11);
    idle_chk("R12", 5'd12, 32'd7);
    idle_chk("R30", 5'd30, 32'hFFFFFF04);
    idle_chk("R20", 5'd20, 32'hC0000000);
    idle_chk("R21", 5'd21, 32'h40000000);
    idle_chk("R2",  5'd2,  32'h80000000);
    idle_chk("R3",  5'd3,  32'd1);
    idle_chk("R5",  5'd5,  32'hFFFFFFF1);

    // Backpressure: a dependent SUB waits three cycles, then forwards
    step(1, mk(0, 4'b0000, 5'd6, 5'd4, rr(5'd7)), 0, 0, 1, 5'd6);
    for (int i = 0; i < 3; i++)
      step(1, mk(0, 4'b0001, 5'd8, 5'd6, rr(5'd4)), 0, 0, 0, 5'd6);
    step(1, mk(0, 4'b0001, 5'd8, 5'd6, rr(5'd4)), 0, 0, 1, 5'd6);
    drain();
    idle_chk("R6", 5'd6, 32'd11);
    idle_chk("R8", 5'd8, 32'd7);

    // Randomized traffic over a small register window to force dependencies
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0,
           mk($urandom % 2, 4'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              16'($urandom)),
           ($urandom % 4) == 0, $urandom, ($urandom % 4) != 0, 5'($urandom));
    end
    drain();

    // Reset while an instruction is held in the commit stage
    step(1, mk(0, 4'd0, 5'd13, 5'd0, 16'h0), 1, 32'hDEAD, 0, 5'd13);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("mid_rst_out_data",  {32'b0, bus.out_data},  64'd0);
    chk("mid_rst_out_rc",    {59'b0, bus.out_rc},    64'd0);
    foreach (crf[i]) begin
      if (crf[i] != 32'd0) begin
        bus.dbg_addr = 5'(i);
        #1;
        chk("mid_rst_dbg", {32'b0, bus.dbg_data}, 64'd0);
      end
    end
    q.delete();
    for (int i = 0; i < 32; i++) begin arf[i] = '0; crf[i] = '0; end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drain();
    idle_chk("R13_dropped", 5'd13, 32'd0);
    idle_chk("R4_cleared",  5'd4,  32'd0);

    // Narrow variant: WIDTH=16, NREGS=8
    @(negedge clk);
    bus2.in_valid = 1'b1; bus2.ir = mk(0, 4'd0, 5'd9, 5'd0, 16'h0);
    bus2.ext_sel = 1'b1; bus2.ext_data = 16'h1234;
    @(negedge clk);
    bus2.ir = mk(0, 4'd0, 5'd3, 5'd0, 16'h0); bus2.ext_data = 16'h0005;
    #1;
    chk("s_out_rc_r9",   {59'b0, bus2.out_rc},   64'd9);
    chk("s_out_data_r9", {48'b0, bus2.out_data}, 64'h1234);
    @(negedge clk);
    bus2.ir = mk(1, 4'b0000, 5'd5, 5'd3, 16'hFFFF); bus2.ext_sel = 1'b0;
    #1;
    chk("s_out_data_r3", {48'b0, bus2.out_data}, 64'h0005);
    @(negedge clk);
    bus2.ir = mk(0, 4'd0, 5'd7, 5'd0, 16'h0); bus2.ext_sel = 1'b1; bus2.ext_data = 16'h8000;
    #1;
    chk("s_out_data_add", {48'b0, bus2.out_data}, 64'h0004);
    chk("s_out_ovf_add",  {63'b0, bus2.out_ovf},  64'd0);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    #1;
    chk("s_out_data_r7", {48'b0, bus2.out_data}, 64'h8000);
    @(negedge clk);
    bus2.dbg_addr = 5'd9; #1;
    chk("s_dbg_r9", {48'b0, bus2.dbg_data}, 64'h0);
    bus2.dbg_addr = 5'd3; #1;
    chk("s_dbg_r3", {48'b0, bus2.dbg_data}, 64'h0005);
    bus2.dbg_addr = 5'd5; #1;
    chk("s_dbg_r5", {48'b0, bus2.dbg_data}, 64'h0004);
    bus2.dbg_addr = 5'd7; #1;
    chk("s_dbg_r7", {48'b0, bus2.dbg_data}, 64'h8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
